// File: rtl/button_event_decoder.sv
// Purpose: classify debounced push-button gestures into single/double/long one-cycle event pulses.
// Latency: long_press LONG_CYCLES after the sampled rise, single_click DCLICK_CYCLES after the sampled fall, double_click at the sampled second fall.
// Backpressure: none; events are fire-and-forget pulses, and the consumer must sample them every cycle.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int DCLICK_CYCLES = 30_000_000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } state_t;

    // Terminal counts: the counter is cleared on entry, so value N-1 marks the Nth cycle.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             btn_q;
    logic             rise;
    logic             fall;
    logic             single_nxt;
    logic             double_nxt;
    logic             long_nxt;

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    // Previous-level register; it keeps tracking the button during reset so a
    // button held through reset does not look like a fresh press afterwards.
    always_ff @(posedge clk) begin
        btn_q <= btn_level;
    end

    // State, counter and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            single_click <= single_nxt;
            double_click <= double_nxt;
            long_press   <= long_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

    // Gesture classification: next state, counter and event pulses.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = PRESS1;
                end
            end
            PRESS1: begin
                // A release on the threshold cycle still counts as a click.
                if (fall) begin
                    state_nxt = WAIT2;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                // Long press already reported; just wait for release.
                cnt_nxt = '0;
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
            WAIT2: begin
                // A second press on the last window cycle still counts as a double.
                if (rise) begin
                    state_nxt = PRESS2;
                    cnt_nxt   = '0;
                end else if (cnt == DCLICK_LAST) begin
                    single_nxt = 1'b1;
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESS2: begin
                // Hold length of the second press is irrelevant.
                cnt_nxt = '0;
                if (fall) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
